alu_issue_seq: RTL and testbench
================================

Name: alu_issue_seq

Overview:
- Initiator side of the ALU start/instruction/rvalid interface.
- Buffers up to DEPTH 12-bit ALU instructions loaded by a host. On go, issues them one at a time to the ALU top. Each result ({cb, result[3:0]}) is captured and streamed out in issue order.
- Contains the issue FSM, the instruction buffer and a response-timeout watchdog.

Parameters:
- INSTR_LENGTH, 12: instruction width; bit 11 funct, [10:7] a, [6:3] b, [2:0] opcode.
- DEPTH, 8: instruction buffer entries; power of two, at least 2.
- TIMEOUT, 15: maximum number of cycles to wait for rvalid after start.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- load_valid, input, 1: host presents an instruction.
- load_instr, input, INSTR_LENGTH: instruction to buffer.
- load_ready, output, 1: buffer accepts; high when state is IDLE and the buffer is not full.
- go, input, 1: begin issuing the buffered instructions.
- start, output, 1: one-cycle issue pulse to the ALU.
- instruction, output, INSTR_LENGTH: instruction driven to the ALU.
- result, input, 4: ALU result.
- cb, input, 1: ALU carry/borrow.
- rvalid, input, 1: ALU result valid.
- res_valid, output, 1: one-cycle pulse, captured result available.
- res_data, output, 5: {cb, result} as captured.
- res_index, output, log2(DEPTH): buffer index of the instruction that produced res_data.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the last result or after an abort.
- timeout_err, output, 1: sticky error flag; cleared by reset or by the next accepted go.

Behaviour:
- Reset (async, reset_n low):
  - state IDLE; buffer count and read/write pointers 0.
  - start, res_valid, done, timeout_err, busy = 0; instruction, res_data, res_index = 0.
  - Buffer contents need not be cleared.
  - A reset asserted mid-issue aborts the run; no done pulse is produced.
- Load:
  - In IDLE, load_valid & load_ready writes load_instr at wr_ptr; wr_ptr++ and count++.
  - When full, load_ready=0 and load_valid is ignored.
  - Loads outside IDLE are ignored (load_ready=0).
- go:
  - Sampled only in IDLE.
  - go with count=0: done pulses the next cycle; state stays IDLE.
  - go with count>0: rd_ptr=0, timeout_err cleared, state goes to ISSUE.
  - go and load_valid in the same cycle: the load is accepted first and the run includes that instruction.
- FSM states: IDLE, ISSUE, WAIT, NEXT, FINISH.
  - ISSUE (1 cycle): start=1 and instruction=buf[rd_ptr]. The timeout counter is cleared. Next state WAIT.
  - WAIT:
    - start=0; instruction holds its value from the ISSUE cycle, stable until rvalid is seen.
    - rvalid is not accepted in the ISSUE cycle itself; the earliest accepted rvalid is the cycle after start.
    - On rvalid=1: register res_data={cb,result} and res_index=rd_ptr; res_valid=1 the following cycle (1-cycle latency). Next state NEXT.
    - Otherwise the counter increments. When the counter reaches TIMEOUT without rvalid: set timeout_err and go to FINISH. The remaining instructions are not issued.
  - NEXT (1 cycle): if rd_ptr == count-1 go to FINISH; else rd_ptr++ and go to ISSUE.
    - Exactly one idle cycle separates consecutive start pulses after each rvalid; start is never re-asserted while waiting.
  - FINISH (1 cycle): done=1; count, rd_ptr and wr_ptr reset to 0 (buffer emptied); next state IDLE.
- rvalid outside WAIT is ignored.
- Result order equals load order.
- res_valid is never asserted for an instruction that timed out.
- Pointers are log2(DEPTH) bits; count is log2(DEPTH)+1 bits, so full means count == DEPTH. wr_ptr wraps to 0 after a full load; rd_ptr never passes count-1.

Test Plan:
- Load 3 instructions (0x1A3, 0x845, 0x0F0). Pulse go. ALU model returns rvalid 2 cycles after each start. Required:
  - 3 start pulses, each instruction stable until its rvalid;
  - res_index 0, 1, 2, with res_data matching the model values;
  - done one cycle after the NEXT that follows the last rvalid;
  - busy low afterwards.
- Load 8 entries with a ninth load_valid asserted. Required: load_ready=0 after the 8th write; the 9th is ignored; go issues exactly 8 starts.
- ALU model never asserts rvalid on the second instruction. Required: timeout_err=1 after 15 wait cycles, done pulses, only 1 res_valid, the third instruction is never issued. The next go clears timeout_err.
- go with an empty buffer -> done pulses the next cycle, no start, busy stays 0.
- Spurious rvalid in IDLE and in the ISSUE cycle -> no res_valid generated.
- reset_n driven low during WAIT of the second instruction. Required: all outputs 0 immediately (asynchronous), state IDLE, no done; a fresh load plus go afterwards operates normally.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Buffers host-loaded ALU instructions and issues them one at a time on go; results stream out in load order.
// Latency: start 1 cycle after go, res_valid 1 cycle after rvalid; load_ready drops when full or not IDLE.
module alu_issue_seq #(
   parameter int INSTR_LENGTH = 12,
   parameter int DEPTH        = 8,
   parameter int TIMEOUT      = 15
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load_valid,
   input  logic [INSTR_LENGTH-1:0]  load_instr,
   output logic                     load_ready,
   input  logic                     go,
   output logic                     start,
   output logic [INSTR_LENGTH-1:0]  instruction,
   input  logic [3:0]               result,
   input  logic                     cb,
   input  logic                     rvalid,
   output logic                     res_valid,
   output logic [4:0]               res_data,
   output logic [$clog2(DEPTH)-1:0] res_index,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

   state_t                  state;
   logic [INSTR_LENGTH-1:0] instr_mem [DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;
   logic [CW-1:0]           count;
   logic [CW-1:0]           count_nxt;
   logic [TW-1:0]           tmo_cnt;
   logic                    load_fire;

   assign load_ready = (state == IDLE) && (count != CW'(DEPTH));
   assign load_fire  = load_valid && load_ready;
   assign count_nxt  = count + CW'(load_fire);
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      if (load_fire) instr_mem[wr_ptr] <= load_instr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         tmo_cnt     <= '0;
         start       <= 1'b0;
         instruction <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_index   <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         start     <= 1'b0;
         res_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (load_fire) begin
                  wr_ptr <= wr_ptr + PW'(1);
                  count  <= count_nxt;
               end
               if (go) begin
                  if (count_nxt == '0) begin
                     done <= 1'b1;
                  end else begin
                     // A load in the go cycle into an empty buffer bypasses the memory write.
                     rd_ptr      <= '0;
                     timeout_err <= 1'b0;
                     start       <= 1'b1;
                     instruction <= (load_fire && count == '0) ? load_instr : instr_mem[PW'(0)];
                     state       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end
            WAIT: begin
               if (rvalid) begin
                  res_data  <= {cb, result};
                  res_index <= rd_ptr;
                  res_valid <= 1'b1;
                  state     <= NEXT;
               end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  done        <= 1'b1;
                  state       <= FINISH;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            NEXT: begin
               if ({1'b0, rd_ptr} == count - CW'(1)) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  rd_ptr      <= rd_ptr + PW'(1);
                  instruction <= instr_mem[rd_ptr + PW'(1)];
                  start       <= 1'b1;
                  state       <= ISSUE;
               end
            end
            FINISH: begin
               count  <= '0;
               rd_ptr <= '0;
               wr_ptr <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a delayed-response ALU model and a result/start monitor.
module tb_alu_issue_seq;

   logic        clk = 1'b0;
   logic        reset_n, load_valid, go, cb, rvalid;
   logic [11:0] load_instr, instruction;
   logic [3:0]  result;
   logic        load_ready, start, res_valid, busy, done, timeout_err;
   logic [4:0]  res_data;
   logic [2:0]  res_index;

   always #5 clk = ~clk;

   logic        m_rvalid = 1'b0, m_cb = 1'b0, spur = 1'b0;
   logic [3:0]  m_result = 4'h0;
   assign rvalid = m_rvalid | spur;
   assign result = m_result;
   assign cb     = m_cb;

   alu_issue_seq #(.INSTR_LENGTH(12), .DEPTH(8), .TIMEOUT(15)) dut (
      .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_instr(load_instr),
      .load_ready(load_ready), .go(go), .start(start), .instruction(instruction),
      .result(result), .cb(cb), .rvalid(rvalid), .res_valid(res_valid), .res_data(res_data),
      .res_index(res_index), .busy(busy), .done(done), .timeout_err(timeout_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] alu_f(input logic [11:0] i);
      return {1'b0, i[10:7]} + {1'b0, i[6:3]} + {4'b0, i[11]};
   endfunction

   // ALU model: answers rvalid 'delay' cycles after each start unless that instruction is dropped.
   int          delay = 2;
   logic        drop_en = 1'b0;
   logic [11:0] drop_instr = 12'h0;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [11:0] held = 12'h0;
   logic [4:0]  pres = 5'h0;
   int          stab_err = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         pend     <= 1'b0;
         m_rvalid <= 1'b0;
      end else begin
         if (pend && cnt == 1) begin
            m_rvalid           <= 1'b1;
            {m_cb, m_result}   <= pres;
            pend               <= 1'b0;
         end else begin
            m_rvalid <= 1'b0;
            if (pend) cnt <= cnt - 1;
         end
         if (pend && instruction !== held) stab_err <= stab_err + 1;
         if (start && !(drop_en && instruction == drop_instr)) begin
            pend <= 1'b1;
            cnt  <= delay;
            pres <= alu_f(instruction);
            held <= instruction;
         end
      end
   end

   int          cyc = 0;
   logic [11:0] q_iss[$];
   int          q_scyc[$];
   logic [4:0]  q_rd[$];
   logic [2:0]  q_ri[$];
   int          q_rcyc[$];
   int          done_cnt = 0;
   int          last_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset_n) begin
         if (start) begin
            q_iss.push_back(instruction);
            q_scyc.push_back(cyc);
         end
         if (res_valid) begin
            q_rd.push_back(res_data);
            q_ri.push_back(res_index);
            q_rcyc.push_back(cyc);
         end
         if (done) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [11:0] v);
      load_instr = v;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [11:0] t1_i [3] = '{12'h1A3, 12'h845, 12'h0F0};
   logic [4:0]  t1_r [3] = '{5'h07, 5'h09, 5'h0F};
   logic [11:0] t2_i [9] = '{12'h7FF, 12'h001, 12'h880, 12'hFFF, 12'h123,
                             12'h456, 12'h789, 12'hABC, 12'hDEF};
   int bs, br, bd;

   initial begin
      reset_n = 1'b0; load_valid = 1'b0; go = 1'b0; load_instr = 12'h0;
      repeat (3) tick();
      chk("rst_start", start, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_instruction", instruction, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_index", res_index, 0);
      reset_n = 1'b1;
      tick();
      chk("rst_load_ready", load_ready, 1);

      // Three-instruction run
      bs = q_iss.size(); br = q_rd.size(); bd = done_cnt;
      for (int k = 0; k < 3; k++) ld(t1_i[k]);
      go = 1'b1; tick(); go = 1'b0;
      chk("t1_start_after_go", start, 1);
      chk("t1_busy", busy, 1);
      chk("t1_first_instr", instruction, 12'h1A3);
      chk("t1_load_ready_busy", load_ready, 0);
      repeat (20) tick();
      chk("t1_starts", q_iss.size() - bs, 3);
      chk("t1_results", q_rd.size() - br, 3);
      for (int k = 0; k < 3; k++) begin
         chk("t1_issued", q_iss[bs + k], t1_i[k]);
         chk("t1_res_data", q_rd[br + k], t1_r[k]);
         chk("t1_res_index", q_ri[br + k], k);
      end
      chk("t1_start_gap0", q_scyc[bs + 1] - q_scyc[bs], 4);
      chk("t1_start_gap1", q_scyc[bs + 2] - q_scyc[bs + 1], 4);
      chk("t1_done_cnt", done_cnt - bd, 1);
      chk("t1_done_timing", last_done - q_rcyc[br + 2], 1);
      chk("t1_instr_stable", stab_err, 0);
      chk("t1_busy_after", busy, 0);
      chk("t1_no_timeout", timeout_err, 0);

      // Fill to capacity with an extra load attempt
      bs = q_iss.size(); br = q_rd.size(); bd = done_cnt;
      for (int i = 0; i < 9; i++) begin
         load_instr = t2_i[i];
         load_valid = 1'b1;
         chk("t2_load_ready", load_ready, (i < 8) ? 1 : 0);
         tick();
      end
      load_valid = 1'b0;
      go = 1'b1; tick(); go = 1'b0;
      repeat (45) tick();
      chk("t2_starts", q_iss.size() - bs, 8);
      chk("t2_results", q_rd.size() - br, 8);
      for (int k = 0; k < 8; k++) begin
         chk("t2_issued", q_iss[bs + k], t2_i[k]);
         chk("t2_res_data", q_rd[br + k], alu_f(t2_i[k]));
         chk("t2_res_index", q_ri[br + k], k);
      end
      chk("t2_res0_carry", q_rd[br], 5'h1E);
      chk("t2_done_cnt", done_cnt - bd, 1);
      chk("t2_instr_stable", stab_err, 0);

      // Second instruction never answered
      bs = q_iss.size(); br = q_rd.size(); bd = done_cnt;
      drop_en = 1'b1; drop_instr = 12'h222;
      ld(12'h111); ld(12'h222); ld(12'h333);
      go = 1'b1; tick(); go = 1'b0;
      repeat (30) tick();
      chk("t3_starts", q_iss.size() - bs, 2);
      chk("t3_second_instr", q_iss[bs + 1], 12'h222);
      chk("t3_results", q_rd.size() - br, 1);
      chk("t3_res_index", q_ri[br], 0);
      chk("t3_res_data", q_rd[br], 5'h04);
      chk("t3_done_cnt", done_cnt - bd, 1);
      chk("t3_timeout_latency", last_done - q_scyc[bs + 1], 16);
      chk("t3_timeout_err", timeout_err, 1);
      chk("t3_busy_after", busy, 0);
      drop_en = 1'b0;
      ld(12'h444);
      chk("t3_err_sticky", timeout_err, 1);
      go = 1'b1; tick(); go = 1'b0;
      chk("t3_err_cleared", timeout_err, 0);
      repeat (10) tick();
      chk("t3_rerun_data", q_rd[q_rd.size() - 1], alu_f(12'h444));

      // Spurious rvalid in IDLE and in the ISSUE cycle
      bs = q_iss.size(); br = q_rd.size();
      spur = 1'b1; tick(); tick(); spur = 1'b0;
      chk("t4_idle_spur", q_rd.size() - br, 0);
      drop_en = 1'b1; drop_instr = 12'h555;
      ld(12'h555);
      go = 1'b1; tick(); go = 1'b0;
      chk("t4_in_issue", start, 1);
      spur = 1'b1; tick(); spur = 1'b0;
      repeat (20) tick();
      chk("t4_issue_spur", q_rd.size() - br, 0);
      chk("t4_issue_timeout", timeout_err, 1);
      chk("t4_starts", q_iss.size() - bs, 1);
      drop_en = 1'b0;

      // go with an empty buffer
      bs = q_iss.size(); bd = done_cnt;
      go = 1'b1; tick(); go = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      tick();
      chk("t5_done_pulse", done, 0);
      chk("t5_no_start", q_iss.size() - bs, 0);
      chk("t5_done_cnt", done_cnt - bd, 1);

      // Reset during WAIT of the second instruction
      ld(12'h0AA); ld(12'h0BB);
      go = 1'b1; tick(); go = 1'b0;
      repeat (5) tick();
      chk("t6_waiting_busy", busy, 1);
      chk("t6_waiting_instr", instruction, 12'h0BB);
      bd = done_cnt;
      #2 reset_n = 1'b0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_instruction", instruction, 0);
      chk("t6_res_data", res_data, 0);
      chk("t6_res_index", res_index, 0);
      chk("t6_start", start, 0);
      chk("t6_load_ready", load_ready, 1);
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      chk("t6_no_done", done_cnt - bd, 0);
      bs = q_iss.size(); br = q_rd.size(); bd = done_cnt;
      load_instr = 12'h0F0; load_valid = 1'b1; go = 1'b1;
      tick();
      load_valid = 1'b0; go = 1'b0;
      chk("t6_go_load_start", start, 1);
      chk("t6_go_load_instr", instruction, 12'h0F0);
      repeat (10) tick();
      chk("t6_starts", q_iss.size() - bs, 1);
      chk("t6_res_data_after", q_rd[br], 5'h0F);
      chk("t6_res_index_after", q_ri[br], 0);
      chk("t6_done_after", done_cnt - bd, 1);
      chk("t6_busy_after", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
